// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and constants for the front-panel run controller
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STEP   = 3'd1,
        ST_RUN    = 3'd2,
        ST_FAST   = 3'd3,
        ST_LOAD   = 3'd4,
        ST_LOADNX = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam int RUN_DIV_DEF   = 4;
    localparam int BURST_LEN_DEF = 8;

    localparam int NUM_BTN   = 5;
    localparam int BTN_STEP  = 0;
    localparam int BTN_RUN   = 1;
    localparam int BTN_SPEED = 2;
    localparam int BTN_HALT  = 3;
    localparam int BTN_LOAD  = 4;

    // Monitor layout: {state[2:0], 1'b0, burst_left[3:0]}
    function automatic logic [7:0] pack_monitor(input state_e st, input logic [3:0] burst);
        return {st, 1'b0, burst};
    endfunction

endpackage

// File: rtl/run_controller_if.sv
// rtl/run_controller_if.sv - control interface between run controller and program counter
interface run_controller_if;
    logic       NEXT;
    logic       RUN;
    logic       SPEEDRUN;
    logic       mode;
    logic [7:0] value;
    logic [7:0] STEP;
    logic [7:0] count;

    modport master (output NEXT, RUN, SPEEDRUN, mode, value, STEP, input count);
    modport slave  (input NEXT, RUN, SPEEDRUN, mode, value, STEP, output count);
endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registers panel button levels and emits one-cycle rising-edge events
module btn_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] btn_q;
    logic [WIDTH-1:0] btn_d;

    always_comb btn_d = btn;

    always_ff @(posedge clk) begin
        if (rst) btn_q <= '0;
        else     btn_q <= btn_d;
    end

    assign rise = btn & ~btn_q;
endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - panel run-control sequencer driving the program counter control stream
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int         RUN_DIV   = RUN_DIV_DEF,
    parameter int         BURST_LEN = BURST_LEN_DEF,
    parameter logic [7:0] STEP_VAL  = 8'd1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_step,
    input  logic                      btn_run,
    input  logic                      btn_speed,
    input  logic                      btn_halt,
    input  logic                      btn_load,
    input  logic [7:0]                load_value,
    input  logic                      bp_en,
    input  logic [7:0]                breakpoint,
    run_controller_if.master          ctl,
    output logic [7:0]                monitor_signal
);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]       burst_left_q, burst_left_d;
    logic             resume_q, resume_d;
    logic [7:0]       value_q, value_d;

    logic [NUM_BTN-1:0] ev;
    logic ev_step, ev_run, ev_speed, ev_halt, ev_load;
    logic div_wrap, bp_hit;
    logic next_o, run_o, fast_o, mode_o;

    btn_edge #(.WIDTH(NUM_BTN)) u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  ({btn_load, btn_halt, btn_speed, btn_run, btn_step}),
        .rise (ev)
    );

    assign ev_step  = ev[BTN_STEP];
    assign ev_run   = ev[BTN_RUN];
    assign ev_speed = ev[BTN_SPEED];
    assign ev_halt  = ev[BTN_HALT];
    assign ev_load  = ev[BTN_LOAD];

    assign div_wrap = (div_cnt_q == DIV_W'(RUN_DIV - 1));
    // Resume masks the breakpoint until the first NEXT moves execution off it
    assign bp_hit   = bp_en && (ctl.count == breakpoint) && !resume_q &&
                      ((state_q == ST_RUN) || (state_q == ST_FAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            burst_left_q <= '0;
            resume_q     <= 1'b0;
            value_q      <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            burst_left_q <= burst_left_d;
            resume_q     <= resume_d;
            value_q      <= value_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        burst_left_d = burst_left_q;
        resume_d     = resume_q;
        value_d      = value_q;
        if (next_o) resume_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev_halt) begin
                    state_d = ST_IDLE;
                end else if (ev_load) begin
                    state_d = ST_LOAD;
                    value_d = load_value;
                end else if (ev_step) begin
                    state_d = ST_STEP;
                end else if (ev_speed) begin
                    state_d      = ST_FAST;
                    burst_left_d = 8'(BURST_LEN);
                end else if (ev_run) begin
                    state_d   = ST_RUN;
                    div_cnt_d = '0;
                    resume_d  = 1'b0;
                end
            end
            ST_STEP: state_d = ST_IDLE;
            ST_RUN: begin
                if (ev_halt)     state_d = ST_IDLE;
                else if (bp_hit) state_d = ST_HALT;
                else             div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
            end
            ST_FAST: begin
                if (ev_halt) begin
                    state_d = ST_IDLE;
                end else if (bp_hit) begin
                    state_d = ST_HALT;
                end else begin
                    burst_left_d = burst_left_q - 8'd1;
                    if (burst_left_q == 8'd1) state_d = ST_IDLE;
                end
            end
            ST_LOAD:   state_d = ST_LOADNX;
            ST_LOADNX: state_d = ST_IDLE;
            ST_HALT: begin
                if (ev_halt) begin
                    state_d = ST_IDLE;
                end else if (ev_run) begin
                    state_d   = ST_RUN;
                    div_cnt_d = '0;
                    resume_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A halt edge aborts RUN/FAST at once, so it also suppresses that cycle's NEXT
    always_comb begin
        next_o = 1'b0;
        run_o  = 1'b0;
        fast_o = 1'b0;
        mode_o = 1'b0;
        case (state_q)
            ST_STEP:   next_o = 1'b1;
            ST_RUN: begin
                run_o  = 1'b1;
                next_o = div_wrap && !bp_hit && !ev_halt;
            end
            ST_FAST: begin
                fast_o = 1'b1;
                next_o = !bp_hit && !ev_halt;
            end
            ST_LOAD:   mode_o = 1'b1;
            ST_LOADNX: begin
                mode_o = 1'b1;
                next_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctl.NEXT       = next_o;
    assign ctl.RUN        = run_o;
    assign ctl.SPEEDRUN   = fast_o;
    assign ctl.mode       = mode_o;
    assign ctl.value      = value_q;
    assign ctl.STEP       = STEP_VAL;
    assign monitor_signal = pack_monitor(state_q, burst_left_q[3:0]);
endmodule
